// File: rtl/mod_exp_param_pkg.sv
// Shared types and latency helper for the mod_exp_param engine and its bench.
// Mode encoding matches the 2-bit mode input; state_t is also the debug view of the FSM.
package mod_exp_pkg;

    typedef enum logic [1:0] {
        MODE_SM   = 2'd0,
        MODE_SMA  = 2'd1,
        MODE_ML   = 2'd2,
        MODE_RSVD = 2'd3
    } mode_t;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CHECK = 3'd1,
        ST_ISSUE = 3'd2,
        ST_WAIT  = 3'd3,
        ST_NEXT  = 3'd4,
        ST_DONE  = 3'd5
    } state_t;

    // Cycles one modular multiply costs inside the engine: issue, WIDTH iterations, write-back.
    function automatic int mul_cycles(input int width);
        return width + 2;
    endfunction

endpackage

// File: rtl/mod_exp_param_mod_mul.sv
// Bit-serial interleaved shift-add modular multiplier: p = a*b mod n, inputs must be < n.
// done pulses exactly WIDTH+1 cycles after start; p holds until the next start.
module mod_mul #(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] n,
    output logic             done,
    output logic [WIDTH-1:0] p
);

    localparam int CW = $clog2(WIDTH + 1);

    logic [WIDTH+1:0] acc_q;
    logic [WIDTH+1:0] acc_d;
    logic [WIDTH+1:0] t_dbl;
    logic [WIDTH+1:0] t_sub;
    logic [WIDTH+1:0] n_ext;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] n_q;
    logic [CW-1:0]    cnt_q;
    logic             run_q;
    logic             done_q;

    // acc < n keeps the top two bits clear, so 2*acc + b < 3n fits in WIDTH+2 bits.
    always_comb begin
        n_ext = {2'b00, n_q};
        t_dbl = {acc_q[WIDTH:0], 1'b0} + (a_q[WIDTH-1] ? {2'b00, b_q} : '0);
        t_sub = (t_dbl >= n_ext) ? t_dbl - n_ext : t_dbl;
        acc_d = (t_sub >= n_ext) ? t_sub - n_ext : t_sub;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q  <= '0;
            a_q    <= '0;
            b_q    <= '0;
            n_q    <= '0;
            cnt_q  <= '0;
            run_q  <= 1'b0;
            done_q <= 1'b0;
        end else if (start) begin
            acc_q  <= '0;
            a_q    <= a;
            b_q    <= b;
            n_q    <= n;
            cnt_q  <= CW'(WIDTH);
            run_q  <= 1'b1;
            done_q <= 1'b0;
        end else if (run_q) begin
            acc_q <= acc_d;
            a_q   <= a_q << 1;
            cnt_q <= cnt_q - CW'(1);
            if (cnt_q == CW'(1)) begin
                run_q  <= 1'b0;
                done_q <= 1'b1;
            end
        end else begin
            done_q <= 1'b0;
        end
    end

    assign done = done_q;
    assign p    = acc_q[WIDTH-1:0];

endmodule

// File: rtl/mod_exp_param.sv
// Modular exponentiation R = M^d mod N with run-time selectable SM / SMA / Montgomery ladder,
// all products through one shared mod_mul. dbg_state exposes the FSM for checkers.
module mod_exp_param
    import mod_exp_pkg::*;
#(
    parameter int WIDTH     = 64,
    parameter int KEY_WIDTH = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 go,
    input  logic [1:0]           mode,
    input  logic [WIDTH-1:0]     M,
    input  logic [WIDTH-1:0]     N,
    input  logic [KEY_WIDTH-1:0] d,
    output logic                 busy,
    output logic                 done,
    output logic                 err,
    output logic [WIDTH-1:0]     R,
    output state_t               dbg_state
);

    localparam int IW = (KEY_WIDTH > 1) ? $clog2(KEY_WIDTH) : 1;

    state_t               state_q, state_d;
    mode_t                mode_q;
    logic [WIDTH-1:0]     n_q;
    logic [WIDTH-1:0]     r0_q;
    logic [WIDTH-1:0]     r1_q;
    logic [KEY_WIDTH-1:0] d_q;
    logic [IW-1:0]        i_q;
    logic                 op_q;
    logic [WIDTH-1:0]     r_q;
    logic                 err_q;

    logic [IW-1:0]        bit_idx;
    logic                 cur_bit;
    logic                 last_op;
    logic                 wr_r0;
    logic                 wr_r1;
    logic [WIDTH-1:0]     mul_a;
    logic [WIDTH-1:0]     mul_b;
    logic                 mul_start;
    logic                 mul_done;
    logic [WIDTH-1:0]     mul_p;
    logic [WIDTH-1:0]     r0_wb;
    logic                 operands_bad;

    // NEXT issues the first product of the following bit, so it looks one index ahead.
    // R1 holds M for SM/SMA (never written there) and the ladder's second register for ML.
    always_comb begin
        bit_idx = (state_q == ST_NEXT) ? i_q - IW'(1) : i_q;
        cur_bit = d_q[bit_idx];
        mul_a   = r0_q;
        mul_b   = r0_q;
        wr_r0   = 1'b0;
        wr_r1   = 1'b0;
        case (mode_q)
            MODE_ML: begin
                if (cur_bit) begin
                    if (!op_q) begin
                        mul_b = r1_q;
                        wr_r0 = 1'b1;
                    end else begin
                        mul_a = r1_q;
                        mul_b = r1_q;
                        wr_r1 = 1'b1;
                    end
                end else begin
                    if (!op_q) begin
                        mul_b = r1_q;
                        wr_r1 = 1'b1;
                    end else begin
                        wr_r0 = 1'b1;
                    end
                end
            end
            default: begin
                if (op_q) begin
                    mul_b = r1_q;
                    wr_r0 = (mode_q == MODE_SM) || cur_bit;
                end else begin
                    wr_r0 = 1'b1;
                end
            end
        endcase
        last_op      = (mode_q == MODE_SM && !cur_bit) ? 1'b1 : op_q;
        mul_start    = (state_q == ST_ISSUE) || (state_q == ST_NEXT);
        r0_wb        = wr_r0 ? mul_p : r0_q;
        operands_bad = (n_q < WIDTH'(2)) || (r1_q >= n_q) || (mode_q == MODE_RSVD);
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (go) state_d = ST_CHECK;
            ST_CHECK: state_d = operands_bad ? ST_DONE : ST_ISSUE;
            ST_ISSUE: state_d = ST_WAIT;
            ST_NEXT:  state_d = ST_WAIT;
            ST_WAIT: begin
                if (mul_done) begin
                    if (!last_op)          state_d = ST_ISSUE;
                    else if (i_q == '0)    state_d = ST_DONE;
                    else                   state_d = ST_NEXT;
                end
            end
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode_q <= MODE_SM;
            n_q    <= '0;
            r0_q   <= '0;
            r1_q   <= '0;
            d_q    <= '0;
            i_q    <= '0;
            op_q   <= 1'b0;
            r_q    <= '0;
            err_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (go) begin
                        mode_q <= mode_t'(mode);
                        n_q    <= N;
                        r1_q   <= M;
                        d_q    <= d;
                        err_q  <= 1'b0;
                    end
                end
                ST_CHECK: begin
                    if (operands_bad) begin
                        r_q   <= '0;
                        err_q <= 1'b1;
                    end else begin
                        r0_q <= WIDTH'(1);
                        i_q  <= IW'(KEY_WIDTH - 1);
                        op_q <= 1'b0;
                    end
                end
                ST_NEXT: i_q <= i_q - IW'(1);
                ST_WAIT: begin
                    if (mul_done) begin
                        if (wr_r0) r0_q <= mul_p;
                        if (wr_r1) r1_q <= mul_p;
                        if (!last_op) begin
                            op_q <= 1'b1;
                        end else begin
                            op_q <= 1'b0;
                            if (i_q == '0) r_q <= r0_wb;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    mod_mul #(.WIDTH(WIDTH)) u_mul (
        .clk   (clk),
        .rst   (rst),
        .start (mul_start),
        .a     (mul_a),
        .b     (mul_b),
        .n     (n_q),
        .done  (mul_done),
        .p     (mul_p)
    );

    assign busy      = (state_q != ST_IDLE);
    assign done      = (state_q == ST_DONE);
    assign err       = err_q;
    assign R         = r_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_mod_exp_param.sv
// Scoreboard bench for mod_exp_param at three sizes (8/8, 16/16, 64/64) sharing one clock.
// Drivers push {err, R, done cycle} from a plain-arithmetic model; per-instance monitors pop on done.
module tb_mod_exp_param;
    import mod_exp_pkg::*;

    typedef struct packed {
        logic        err;
        logic [63:0] r;
        logic [31:0] due;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        go8, go16, go64;
    logic [1:0]  mode_s;
    logic [63:0] m_s, n_s, d_s;

    logic        busy8, done8, err8;
    logic [7:0]  r8;
    state_t      dbg8;
    logic        busy16, done16, err16;
    logic [15:0] r16;
    state_t      dbg16;
    logic        busy64, done64, err64;
    logic [63:0] r64;
    state_t      dbg64;

    exp_t exp_q8[$];
    exp_t exp_q16[$];
    exp_t exp_q64[$];
    exp_t e8, e16, e64;
    logic h8, h16, h64;

    int cyc;
    int checks;
    int failures;

    mod_exp_param #(.WIDTH(8), .KEY_WIDTH(8)) u8 (
        .clk(clk), .rst(rst), .go(go8), .mode(mode_s), .M(m_s[7:0]), .N(n_s[7:0]), .d(d_s[7:0]),
        .busy(busy8), .done(done8), .err(err8), .R(r8), .dbg_state(dbg8)
    );
    mod_exp_param #(.WIDTH(16), .KEY_WIDTH(16)) u16 (
        .clk(clk), .rst(rst), .go(go16), .mode(mode_s), .M(m_s[15:0]), .N(n_s[15:0]), .d(d_s[15:0]),
        .busy(busy16), .done(done16), .err(err16), .R(r16), .dbg_state(dbg16)
    );
    mod_exp_param #(.WIDTH(64), .KEY_WIDTH(64)) u64 (
        .clk(clk), .rst(rst), .go(go64), .mode(mode_s), .M(m_s), .N(n_s), .d(d_s),
        .busy(busy64), .done(done64), .err(err64), .R(r64), .dbg_state(dbg64)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- reference model ----------------
    function automatic logic [63:0] mulmod(input logic [63:0] a, input logic [63:0] b, input logic [63:0] n);
        logic [127:0] t;
        t = ({64'b0, a} * {64'b0, b}) % {64'b0, n};
        return t[63:0];
    endfunction

    // Right-to-left binary exponentiation over the low kw exponent bits.
    function automatic logic [63:0] ref_modexp(input logic [63:0] m, input logic [63:0] n,
                                                input logic [63:0] dd, input int kw);
        logic [63:0] r;
        logic [63:0] base;
        r    = 64'd1;
        base = m;
        for (int k = 0; k < kw; k++) begin
            if (dd[k]) r = mulmod(r, base, n);
            base = mulmod(base, base, n);
        end
        return r;
    endfunction

    function automatic exp_t model(input int w, input logic [1:0] md, input logic [63:0] m,
                                   input logic [63:0] n, input logic [63:0] dd);
        exp_t e;
        int   ops;
        e = '0;
        if (n < 64'd2 || m >= n || md == 2'd3) begin
            e.err = 1'b1;
            e.due = 32'd2;
            return e;
        end
        e.r   = ref_modexp(m, n, dd, w);
        ops   = (md == 2'd0) ? w + $countones(dd) : 2 * w;
        e.due = 32'(2 + ops * mul_cycles(w));
        return e;
    endfunction

    // ---------------- scoreboard ----------------
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic score(input string tag, input logic has, input exp_t e, input logic errv,
                         input logic [63:0] rv, input logic busyv);
        if (!has) begin
            checks++;
            failures++;
            $display("FAIL %s_unexpected_done actual=done required=no_done (cycle %0d)", tag, cyc);
        end else begin
            chk({tag, "_R"}, rv, e.r);
            chk({tag, "_err"}, 64'(errv), 64'(e.err));
            chk({tag, "_done_cycle"}, 64'(cyc), 64'(e.due));
            chk({tag, "_busy_at_done"}, 64'(busyv), 64'd1);
        end
    endtask

    always @(negedge clk) begin
        if (done8) begin
            h8 = (exp_q8.size() > 0);
            e8 = h8 ? exp_q8.pop_front() : '0;
            score("w8", h8, e8, err8, 64'(r8), busy8);
        end
        if (done16) begin
            h16 = (exp_q16.size() > 0);
            e16 = h16 ? exp_q16.pop_front() : '0;
            score("w16", h16, e16, err16, 64'(r16), busy16);
        end
        if (done64) begin
            h64 = (exp_q64.size() > 0);
            e64 = h64 ? exp_q64.pop_front() : '0;
            score("w64", h64, e64, err64, r64, busy64);
        end
    end

    // ---------------- driver tasks ----------------
    function automatic int qsize(input int w);
        if (w == 8)  return exp_q8.size();
        if (w == 16) return exp_q16.size();
        return exp_q64.size();
    endfunction

    function automatic logic [63:0] wmask(input int w);
        return (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
    endfunction

    task automatic set_go(input int w, input logic v);
        if (w == 8)       go8  = v;
        else if (w == 16) go16 = v;
        else              go64 = v;
    endtask

    task automatic wait_drain(input int w);
        for (int k = 0; k < 12000; k++) begin
            @(negedge clk);
            if (qsize(w) == 0) break;
        end
        if (qsize(w) != 0) begin
            checks++;
            failures++;
            $display("FAIL w%0d_timeout actual=pending required=done (cycle %0d)", w, cyc);
            if (w == 8) exp_q8.delete();
            else if (w == 16) exp_q16.delete();
            else exp_q64.delete();
        end
    endtask

    // Present one request; with push=0 the request is not expected to complete.
    task automatic issue(input int w, input logic [1:0] md, input logic [63:0] m,
                         input logic [63:0] n, input logic [63:0] dd, input logic push);
        exp_t e;
        @(negedge clk);
        mode_s = md;
        m_s    = m & wmask(w);
        n_s    = n & wmask(w);
        d_s    = dd & wmask(w);
        e      = model(w, md, m_s, n_s, d_s);
        e.due  = e.due + 32'(cyc);
        if (push) begin
            if (w == 8)       exp_q8.push_back(e);
            else if (w == 16) exp_q16.push_back(e);
            else              exp_q64.push_back(e);
        end
        set_go(w, 1'b1);
        @(negedge clk);
        set_go(w, 1'b0);
    endtask

    task automatic run(input int w, input logic [1:0] md, input logic [63:0] m,
                       input logic [63:0] n, input logic [63:0] dd);
        issue(w, md, m, n, dd, 1'b1);
        wait_drain(w);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [63:0] rn, rm, rd;
        cyc = 0; checks = 0; failures = 0;
        rst = 1'b1; go8 = 1'b0; go16 = 1'b0; go64 = 1'b0;
        mode_s = 2'd0; m_s = '0; n_s = '0; d_s = '0;
        repeat (3) @(negedge clk);
        chk("reset_R8", 64'(r8), 64'd0);
        chk("reset_flags8", {61'd0, busy8, done8, err8}, 64'd0);
        chk("reset_state8", 64'(dbg8), 64'(ST_IDLE));
        chk("reset_R64", r64, 64'd0);
        rst = 1'b0;
        @(negedge clk);

        // Textbook RSA-8 vector in every mode.
        for (int md = 0; md < 3; md++) run(8, 2'(md), 64'h58, 64'hBB, 64'h07);
        // Zero and all-ones exponents; SM and ML both cost 16 products at d=0xFF.
        run(8, 2'd0, 64'h05, 64'h0D, 64'h00);
        run(8, 2'd2, 64'h05, 64'h0D, 64'h00);
        run(8, 2'd0, 64'h05, 64'h0D, 64'hFF);
        run(8, 2'd2, 64'h05, 64'h0D, 64'hFF);

        // Operand errors, then a valid request must clear err.
        run(8, 2'd0, 64'h20, 64'h20, 64'h07);
        chk("err_held", 64'(err8), 64'd1);
        run(8, 2'd1, 64'h00, 64'h01, 64'h07);
        run(8, 2'd3, 64'h05, 64'h0D, 64'h07);
        run(8, 2'd1, 64'h58, 64'hBB, 64'h07);

        // go while busy is ignored.
        issue(8, 2'd2, 64'h58, 64'hBB, 64'h07, 1'b1);
        repeat (20) @(negedge clk);
        mode_s = 2'd0; m_s = 64'h03; n_s = 64'h0D; d_s = 64'h05;
        go8 = 1'b1;
        @(negedge clk);
        go8 = 1'b0;
        wait_drain(8);

        // Reset mid-ladder aborts with no done; the next request completes.
        issue(8, 2'd2, 64'h58, 64'hBB, 64'hA5, 1'b0);
        repeat (60) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("abort_R8", 64'(r8), 64'd0);
        chk("abort_flags8", {61'd0, busy8, done8, err8}, 64'd0);
        chk("abort_state8", 64'(dbg8), 64'(ST_IDLE));
        rst = 1'b0;
        repeat (200) @(negedge clk);
        run(8, 2'd2, 64'h58, 64'hBB, 64'hA5);

        // Random small operands, all modes.
        for (int t = 0; t < 12; t++) begin
            rn = 64'($urandom_range(2, 255));
            rm = 64'($urandom_range(0, 32'(rn) - 1));
            rd = 64'($urandom_range(0, 255));
            run(8, 2'($urandom_range(0, 2)), rm, rn, rd);
        end

        // RSA-16: encrypt then decrypt in each mode.
        run(16, 2'd0, 64'd65, 64'd3233, 64'd17);
        for (int md = 0; md < 3; md++) run(16, 2'(md), 64'd2790, 64'd3233, 64'd2753);

        // 64-bit: e=65537 in each mode, then random operands.
        rn = {$urandom, $urandom} | 64'h8000_0000_0000_0001;
        rm = {$urandom, $urandom} % rn;
        for (int md = 0; md < 3; md++) run(64, 2'(md), rm, rn, 64'h0000_0000_0001_0001);
        for (int md = 0; md < 3; md++) begin
            rn = {$urandom, $urandom} | 64'h1;
            if (rn < 64'd2) rn = 64'd3;
            rm = {$urandom, $urandom} % rn;
            rd = {$urandom, $urandom};
            run(64, 2'(md), rm, rn, rd);
        end

        repeat (5) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
